mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, word width; ADDR_W, default 3, memory address width (8 words).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  burst request, sampled only in IDLE.
REQ-005 op_rd  input  1  burst type: 1 = read, 0 = write; sampled with start.
REQ-006 base_addr  input  ADDR_W  first word address; sampled with start.
REQ-007 len  input  ADDR_W+1  word count, legal 1..8; sampled with start.
REQ-008 wr_data  input  DATA_W  write stream payload.
REQ-009 wr_valid  input  1  write stream valid.
REQ-010 wr_ready  output  1  write stream ready; transfer when wr_valid and wr_ready are both 1.
REQ-011 rd_data  output  DATA_W  read stream payload.
REQ-012 rd_valid  output  1  one-cycle qualifier per read word; no backpressure.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on burst completion.
REQ-015 err  output  1  one-cycle pulse on illegal request.
REQ-016 mem_enable, mem_rw, mem_addr[ADDR_W], mem_din[DATA_W]  outputs  memory port; mem_rw 0 = write, 1 = read.
REQ-017 mem_dout  input  DATA_W  memory read data, valid on the edge after a read issue cycle.

Function
REQ-018 States SHALL be IDLE, WR, RD_ISSUE, RD_CAPT, DONE.
REQ-019 IDLE: start with len 1..8 SHALL latch op_rd, base_addr and len, then go to WR (op_rd=0) or RD_ISSUE (op_rd=1).
REQ-020 IDLE: start with len 0 or len > 8 SHALL pulse err for one cycle next cycle, stay in IDLE, and drive no memory access.
REQ-021 start while busy SHALL be ignored.
REQ-022 WR: wr_ready SHALL be 1; each handshake SHALL drive mem_enable=1, mem_rw=0, mem_addr=current address and mem_din=wr_data combinationally in that cycle, then increment the address and decrement the remaining count.
REQ-023 WR with wr_valid=0 SHALL hold mem_enable=0 and keep all state (stall).
REQ-024 RD_ISSUE SHALL drive mem_enable=1, mem_rw=1, mem_addr=current address for one cycle, then go to RD_CAPT.
REQ-025 RD_CAPT SHALL register mem_dout into rd_data, pulse rd_valid for one cycle, and then go to RD_ISSUE if words remain, else DONE.
REQ-026 Read throughput SHALL be one word per 2 cycles; latency from the start edge to the first rd_valid SHALL be 2 cycles.
REQ-027 Address SHALL wrap modulo 2^ADDR_W (7 -> 0).
REQ-028 The last write or last read capture SHALL go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-029 Outside the cycles in REQ-022 and REQ-024, mem_enable SHALL be 0; mem_rw, mem_addr and mem_din SHALL hold their last values.

Reset
REQ-030 While rst_n=0: state=IDLE; wr_ready, rd_valid, busy, done, err, mem_enable = 0; mem_rw=1; mem_addr, mem_din, rd_data = 0.
REQ-031 Asserting reset mid-burst SHALL abort the burst immediately with no further memory access; the next start after reset release SHALL behave normally.

Structure
REQ-032 A shared package SHALL hold DATA_W and ADDR_W defaults, the state encoding and the op encoding (OP_WR=0, OP_RD=1).
REQ-033 Address and remaining-count tracking SHALL be one sub-module, burst_addr_ctr (load, step, wrap, last flag); everything else SHALL be in mem_burst_ctrl.

Verification
REQ-034 Write base 0, len 2, data AAAA then 00AA, wr_valid held 1 -> memory writes addr0=AAAA, addr1=00AA on consecutive cycles; done pulses once.
REQ-035 Read base 0, len 2 after REQ-034 -> rd_valid twice, 2 cycles apart, rd_data AAAA then 00AA; first rd_valid 2 cycles after start.
REQ-036 Write base 6, len 4, data 00BB/00CC/00DD/00EE -> mem_addr sequence 6,7,0,1 (wrap); read-back matches.
REQ-037 Start with len 0 and with len 9 -> err pulses once each, mem_enable stays 0, busy stays 0.
REQ-038 Write len 3 with wr_valid dropped for 2 cycles after word 1 -> mem_enable low during the gap, address held, all 3 words written in order.
REQ-039 rst_n low after word 2 of a len-5 write -> outputs at reset values immediately, no further writes; a new len-1 read then completes normally.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst memory controller: default widths,
// FSM state encoding and burst-type encoding.
package mem_burst_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_e;

endpackage

// File: rtl/mem_burst_ctrl_addr_ctr.sv
// Burst address / remaining-word tracker: loads base and length, steps one
// word at a time with natural modulo-2^ADDR_W wrap, flags the final word.
module burst_addr_ctr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_len;
    end else if (step) begin
      addr   <= addr + 1'b1;
      remain <= remain - 1'b1;
    end
  end

  // Set while the word currently being transferred is the final one.
  assign last = (remain == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller between a valid/ready write stream, a read stream and a
// single-port synchronous memory (read data returns one edge after issue).
module mem_burst_ctrl
  import mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_rd,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic len_legal(input logic [ADDR_W:0] l);
    return (l != '0) && (l <= MAX_LEN);
  endfunction

  state_e            state, state_nxt;
  op_e               op_in;
  logic              ctr_load, ctr_step, ctr_last;
  logic [ADDR_W-1:0] cur_addr;
  logic              capt, req_bad;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;

  assign op_in = op_e'(op_rd);

  burst_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .load_addr (base_addr),
    .load_len  (len),
    .step      (ctr_step),
    .addr      (cur_addr),
    .last      (ctr_last)
  );

  // Memory port fields default to their held copies so they keep the last
  // issued values whenever no access is made.
  always_comb begin
    state_nxt  = state;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    capt       = 1'b0;
    req_bad    = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = mem_rw_q;
    mem_addr   = mem_addr_q;
    mem_din    = mem_din_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_legal(len)) begin
            ctr_load  = 1'b1;
            state_nxt = (op_in == OP_RD) ? ST_RD_ISSUE : ST_WR;
          end else begin
            req_bad = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (wr_valid) begin
          mem_enable = 1'b1;
          mem_rw     = OP_WR;
          mem_addr   = cur_addr;
          mem_din    = wr_data;
          ctr_step   = 1'b1;
          if (ctr_last) state_nxt = ST_DONE;
        end
      end
      ST_RD_ISSUE: begin
        mem_enable = 1'b1;
        mem_rw     = OP_RD;
        mem_addr   = cur_addr;
        state_nxt  = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        capt      = 1'b1;
        ctr_step  = 1'b1;
        state_nxt = ctr_last ? ST_DONE : ST_RD_ISSUE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Registered boundary: held memory port fields, read capture, error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rw_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_rw_q   <= mem_rw;
      mem_addr_q <= mem_addr;
      mem_din_q  <= mem_din;
      rd_valid   <= capt;
      err        <= req_bad;
      if (capt) rd_data <= mem_dout;
    end
  end

  assign wr_ready = (state == ST_WR);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural synchronous memory.
module tb_mem_burst_ctrl;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk, rst_n, start, op_rd, wr_valid;
  logic [2:0]  base_addr;
  logic [3:0]  len;
  logic [15:0] wr_data;
  logic        wr_ready, rd_valid, busy, done, err;
  logic [15:0] rd_data;
  logic        mem_enable, mem_rw;
  logic [2:0]  mem_addr;
  logic [15:0] mem_din, mem_dout;

  logic [15:0] mem_model [8];
  logic [15:0] shadow [8];
  logic [15:0] wdata [8];
  wr_exp_t     exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [2:0]  exp_ra [$];
  int          n_total, n_pass;

  mem_burst_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_rd      (op_rd),
    .base_addr  (base_addr),
    .len        (len),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_enable (mem_enable),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_enable && !mem_rw) mem_model[mem_addr] <= mem_din;
    if (mem_enable && mem_rw)  mem_dout <= mem_model[mem_addr];
  end

  task automatic test_reset();
    @(negedge clk); #1;
    n_total++;
    if ({wr_ready, rd_valid, busy, done, err, mem_enable, mem_rw} !== 7'b0000001)
      $display("FAIL reset_ctrl: got %b want 0000001",
               {wr_ready, rd_valid, busy, done, err, mem_enable, mem_rw});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_din, rd_data} !== 35'd0)
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_din, rd_data});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_total++;
    if ({busy, mem_enable} !== 2'b00) $display("FAIL reset_release: got %b want 00", {busy, mem_enable});
    else n_pass++;
  endtask

  task automatic do_write(input logic [2:0] base, input int n, input int stall_after,
                          input int stall_len, input bit noisy);
    int sent, stalls;
    logic [2:0] last_addr;
    wr_exp_t e;
    sent = 0; stalls = stall_len; last_addr = base;
    @(negedge clk); start = 1'b1; op_rd = 1'b0; base_addr = base; len = 4'(n);
    @(negedge clk);
    start = noisy; op_rd = 1'b1; len = 4'd1; base_addr = 3'd5;
    for (int cyc = 0; cyc < 40 && sent < n; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (sent == stall_after && stalls > 0) begin
        wr_valid = 1'b0; wr_data = 16'hDEAD; stalls--;
      end else begin
        wr_valid = 1'b1; wr_data = wdata[sent];
        e.addr = base + 3'(sent); e.data = wdata[sent];
        exp_wr.push_back(e); shadow[e.addr] = e.data;
      end
      #1;
      n_total++;
      if (wr_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", wr_ready);
      else n_pass++;
      if (wr_valid) begin
        e = exp_wr.pop_front();
        n_total++;
        if ({mem_enable, mem_rw, mem_addr, mem_din} !== {1'b1, 1'b0, e.addr, e.data})
          $display("FAIL wr_access: got en=%b rw=%b a=%0d d=%h want en=1 rw=0 a=%0d d=%h",
                   mem_enable, mem_rw, mem_addr, mem_din, e.addr, e.data);
        else n_pass++;
        last_addr = e.addr; sent++;
      end else begin
        n_total++;
        if ({mem_enable, mem_addr} !== {1'b0, last_addr})
          $display("FAIL wr_stall: got en=%b a=%0d want en=0 a=%0d", mem_enable, mem_addr, last_addr);
        else n_pass++;
      end
    end
    if (sent < n) begin
      n_total++;
      $display("FAIL wr_timeout: got %0d words want %0d", sent, n);
    end
    @(negedge clk); start = 1'b0; wr_valid = 1'b0; #1;
    n_total++;
    if ({done, busy, mem_enable, wr_ready} !== 4'b1100)
      $display("FAIL wr_done: got %b want 1100", {done, busy, mem_enable, wr_ready});
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL wr_idle: got %b want 00", {done, busy});
    else n_pass++;
  endtask

  task automatic do_read(input logic [2:0] base, input int n);
    int got;
    logic [15:0] ev;
    logic [2:0]  ea;
    got = 0;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(shadow[base + 3'(i)]);
      exp_ra.push_back(base + 3'(i));
    end
    @(negedge clk); start = 1'b1; op_rd = 1'b1; base_addr = base; len = 4'(n);
    @(negedge clk); start = 1'b0;
    for (int t = 1; t <= 40 && got < n; t++) begin
      if (t != 1) @(negedge clk);
      #1;
      if (mem_enable) begin
        n_total++;
        if (exp_ra.size() == 0) $display("FAIL rd_extra_issue: got a=%0d want none", mem_addr);
        else begin
          ea = exp_ra.pop_front();
          if ({mem_rw, mem_addr} !== {1'b1, ea})
            $display("FAIL rd_issue: got rw=%b a=%0d want rw=1 a=%0d", mem_rw, mem_addr, ea);
          else n_pass++;
        end
      end
      if (rd_valid) begin
        ev = exp_rd.pop_front();
        n_total++;
        if (rd_data !== ev) $display("FAIL rd_data: got %h want %h", rd_data, ev);
        else n_pass++;
        n_total++;
        if (t !== 3 + 2 * got) $display("FAIL rd_timing: got cycle %0d want %0d", t, 3 + 2 * got);
        else n_pass++;
        n_total++;
        if (done !== (got == n - 1)) $display("FAIL rd_done: got %b want %b", done, (got == n - 1));
        else n_pass++;
        got++;
      end
    end
    if (got < n) begin
      n_total++;
      $display("FAIL rd_timeout: got %0d words want %0d", got, n);
      exp_rd.delete(); exp_ra.delete();
    end
    @(negedge clk); #1;
    n_total++;
    if ({busy, done, rd_valid, mem_enable} !== 4'b0000)
      $display("FAIL rd_idle: got %b want 0000", {busy, done, rd_valid, mem_enable});
    else n_pass++;
  endtask

  task automatic test_write();
    wdata[0] = 16'hAAAA; wdata[1] = 16'h00AA;
    do_write(3'd0, 2, -1, 0, 1'b0);
  endtask

  task automatic test_read();
    do_read(3'd0, 2);
  endtask

  task automatic test_wrap();
    wdata[0] = 16'h00BB; wdata[1] = 16'h00CC; wdata[2] = 16'h00DD; wdata[3] = 16'h00EE;
    do_write(3'd6, 4, -1, 0, 1'b0);
    do_read(3'd6, 4);
    do_read(3'd0, 8);
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); start = 1'b1; op_rd = 1'b0; base_addr = 3'd0; len = bad[k]; #1;
      n_total++;
      if ({busy, err, mem_enable} !== 3'b000)
        $display("FAIL illegal_req: got %b want 000", {busy, err, mem_enable});
      else n_pass++;
      @(negedge clk); start = 1'b0; #1;
      n_total++;
      if ({err, busy, mem_enable} !== 3'b100)
        $display("FAIL illegal_err: got %b want 100", {err, busy, mem_enable});
      else n_pass++;
      @(negedge clk); #1;
      n_total++;
      if ({err, busy, mem_enable} !== 3'b000)
        $display("FAIL illegal_after: got %b want 000", {err, busy, mem_enable});
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    wdata[0] = 16'h0111; wdata[1] = 16'h0222; wdata[2] = 16'h0333;
    do_write(3'd1, 3, 1, 2, 1'b1);
    do_read(3'd1, 3);
  endtask

  task automatic test_reset_abort();
    wr_exp_t e;
    for (int i = 0; i < 5; i++) wdata[i] = 16'h1111 * 16'(i + 1);
    @(negedge clk); start = 1'b1; op_rd = 1'b0; base_addr = 3'd2; len = 4'd5;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i != 0) @(negedge clk);
      wr_valid = 1'b1; wr_data = wdata[i];
      e.addr = 3'd2 + 3'(i); e.data = wdata[i];
      exp_wr.push_back(e); shadow[e.addr] = e.data;
      #1;
      e = exp_wr.pop_front();
      n_total++;
      if ({mem_enable, mem_rw, mem_addr, mem_din} !== {1'b1, 1'b0, e.addr, e.data})
        $display("FAIL abort_wr: got a=%0d d=%h want a=%0d d=%h", mem_addr, mem_din, e.addr, e.data);
      else n_pass++;
    end
    @(negedge clk); rst_n = 1'b0; wr_data = wdata[2]; #1;
    n_total++;
    if ({wr_ready, rd_valid, busy, done, err, mem_enable, mem_rw} !== 7'b0000001)
      $display("FAIL abort_ctrl: got %b want 0000001",
               {wr_ready, rd_valid, busy, done, err, mem_enable, mem_rw});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_din, rd_data} !== 35'd0)
      $display("FAIL abort_data: got %h want 0", {mem_addr, mem_din, rd_data});
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_total++;
      if ({mem_enable, busy} !== 2'b00) $display("FAIL abort_hold: got %b want 00", {mem_enable, busy});
      else n_pass++;
    end
    @(negedge clk); rst_n = 1'b1; wr_valid = 1'b0;
    do_read(3'd3, 1);
    do_read(3'd4, 1);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; op_rd = 1'b0; base_addr = '0; len = '0;
    wr_data = '0; wr_valid = 1'b0; mem_dout = '0;
    for (int i = 0; i < 8; i++) begin
      mem_model[i] = '0; shadow[i] = '0; wdata[i] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_illegal();
    test_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
